aes_scheduler: RTL and testbench

Shares one iterative AES-128 encryption core between `NUM_REQ` requesters. Arbitrates among requests, registers and holds the plaintext/key for the whole operation, and pulses the core start. It then tracks core busy, captures the ciphertext, and returns it with the requester ID on a single valid/ready response channel. The block sits between the CPU-side crypto ports and the AES round datapath. A watchdog covers a stalled core.

---
 rtl/aes_scheduler.sv | 155 +++++++++++++++
 tb/tb_aes_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_scheduler.sv
// aes_scheduler: arbitrates NUM_REQ requesters onto one iterative AES-128 core with a watchdog.
// Define AES_SCHED_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module aes_scheduler #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = $clog2(NUM_REQ),
   parameter int unsigned TIMEOUT = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*128-1:0] req_plaintext,
   input  logic [NUM_REQ*128-1:0] req_secret,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [127:0]           rsp_cipher,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   rsp_err,
   output logic                   core_we,
   output logic [127:0]           core_plaintext,
   output logic [127:0]           core_secret,
   input  logic                   core_busy,
   input  logic [127:0]           core_cipher
);
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [127:0]    pt_q, pt_d, key_q, key_d, cipher_q, cipher_d;
   logic [ID_W-1:0] id_q, id_d, rsp_id_q, rsp_id_d;
   logic            err_q, err_d;
   logic            gnt_vld, grant_ok;
   logic [ID_W-1:0] gnt_idx;

`ifdef AES_SCHED_ROUND_ROBIN_EN
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] cand;

   // Search starts one past the last granted requester.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         cand = ID_W'((int'(ptr_q) + k) % int'(NUM_REQ));
         if (!gnt_vld && req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_ok) ptr_d = gnt_idx;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) ptr_q <= ID_W'(NUM_REQ - 1);
      else          ptr_q <= ptr_d;
   end
`else
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = ID_W'(k);
         end
      end
   end
`endif

   // A busy core in IDLE is a stale run from before a reset or abort; hold off grants.
   assign grant_ok  = (state_q == StIdle) && !core_busy && gnt_vld;
   assign req_ready = grant_ok ? (NUM_REQ'(1) << gnt_idx) : '0;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pt_d     = pt_q;
      key_d    = key_q;
      id_d     = id_q;
      cipher_d = cipher_q;
      rsp_id_d = rsp_id_q;
      err_d    = err_q;
      unique case (state_q)
         StIdle: begin
            if (grant_ok) begin
               pt_d    = req_plaintext[32'(gnt_idx)*128 +: 128];
               key_d   = req_secret[32'(gnt_idx)*128 +: 128];
               id_d    = gnt_idx;
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (!core_busy) begin
               cipher_d = core_cipher;
               err_d    = 1'b0;
               rsp_id_d = id_q;
               state_d  = StResp;
            end else if (cnt_q == CntW'(TIMEOUT)) begin
               cipher_d = '0;
               err_d    = 1'b1;
               rsp_id_d = id_q;
               state_d  = StResp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         pt_q     <= '0;
         key_q    <= '0;
         id_q     <= '0;
         cipher_q <= '0;
         rsp_id_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pt_q     <= pt_d;
         key_q    <= key_d;
         id_q     <= id_d;
         cipher_q <= cipher_d;
         rsp_id_q <= rsp_id_d;
         err_q    <= err_d;
      end
   end

   assign core_we        = (state_q == StIssue);
   assign core_plaintext = pt_q;
   assign core_secret    = key_q;
   assign rsp_valid      = (state_q == StResp);
   assign rsp_cipher     = cipher_q;
   assign rsp_id         = rsp_id_q;
   assign rsp_err        = err_q;

endmodule

// File: tb/tb_aes_scheduler.sv
// Randomized bench for aes_scheduler with a behavioural AES-128 core and arbitration model.
// Expected grant order follows AES_SCHED_ROUND_ROBIN_EN when defined.
module tb_aes_scheduler;
   localparam int NREQ = 2;
   localparam int IDW  = 1;
   localparam int TO   = 32;

   logic                 clock = 1'b0;
   logic                 reset_n;
   logic [NREQ-1:0]      req_valid, req_ready;
   logic [NREQ*128-1:0]  req_plaintext, req_secret;
   logic                 rsp_valid, rsp_ready, rsp_err, core_we, core_busy;
   logic [127:0]         rsp_cipher, core_plaintext, core_secret, core_cipher;
   logic [IDW-1:0]       rsp_id;

   aes_scheduler #(.NUM_REQ(NREQ), .ID_W(IDW), .TIMEOUT(TO)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_plaintext  (req_plaintext),
      .req_secret     (req_secret),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_cipher     (rsp_cipher),
      .rsp_id         (rsp_id),
      .rsp_err        (rsp_err),
      .core_we        (core_we),
      .core_plaintext (core_plaintext),
      .core_secret    (core_secret),
      .core_busy      (core_busy),
      .core_cipher    (core_cipher)
   );

   always #5 clock = ~clock;

   int           n_vec = 0, n_err = 0, cyc = 0, we_count = 0, busy_rem = 0;
   int           last_g, obs_g, acc_cyc, prev_acc, t0, n;
   logic [7:0]   obs_seq;
   logic [127:0] last_cipher, core_res;
   logic [127:0] pt_a [NREQ];
   logic [127:0] key_a [NREQ];
   logic [7:0]   sb [256];
   logic         force_busy;
   bit           q;
   logic [NREQ-1:0] vq = '0, rq = '0;

   // ---------------- AES-128 reference ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   s [16];
      logic [7:0]   k [16];
      logic [7:0]   t [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) begin
         k[i] = key[127-8*i -: 8];
         s[i] = pt[127-8*i -: 8] ^ k[i];
      end
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         a0 = k[12];
         k[0] ^= sb[k[13]] ^ rc;
         k[1] ^= sb[k[14]];
         k[2] ^= sb[k[15]];
         k[3] ^= sb[a0];
         for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
         rc = gmul(rc, 8'h02);
         for (int i = 0; i < 16; i++) s[i] ^= k[i];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // ---------------- core model: busy during T+1..T+13 for an accept in T ----------------
   assign core_busy   = force_busy | core_we | (busy_rem != 0);
   assign core_cipher = core_res;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (core_we) begin
         we_count <= we_count + 1;
         busy_rem <= 12;
         core_res <= aes128(core_plaintext, core_secret);
      end else if (busy_rem != 0) begin
         busy_rem <= busy_rem - 1;
      end
   end

   // Requesters must hold req_valid until their req_ready.
   always @(posedge clock) begin
      if (reset_n)
         for (int i = 0; i < NREQ; i++)
            assert (!(vq[i] && !rq[i] && !req_valid[i]))
               else $error("req_valid[%0d] dropped before req_ready", i);
      vq <= req_valid;
      rq <= req_ready;
   end

   // ---------------- helpers ----------------
   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic drive_bus();
      for (int i = 0; i < NREQ; i++) begin
         req_plaintext[128*i +: 128] = pt_a[i];
         req_secret[128*i +: 128]    = key_a[i];
      end
   endtask

   function automatic int exp_grant(input logic [NREQ-1:0] v, input int last);
`ifdef AES_SCHED_ROUND_ROBIN_EN
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`else
      for (int k = 0; k < NREQ; k++)
         if (v[k]) return k;
`endif
      return -1;
   endfunction

   task automatic check_reset_vals();
      check_eq("rst_ctrl", {req_ready, rsp_valid, rsp_err, core_we, rsp_id}, 0);
      check_eq("rst_core_pt", core_plaintext, 0);
      check_eq("rst_core_key", core_secret, 0);
      check_eq("rst_cipher", rsp_cipher, 0);
   endtask

   // One full operation: grant, issue, wait, response (optionally back-pressured or aborted).
   task automatic do_op(input int bp, input bit stuck, input bit keep);
      int           g, lat, we0, m;
      logic [127:0] ep, ek, ec;
      bit           quiet, stable;
      #1;
      m = 0;
      while (req_ready == '0 && m < 300) begin step(); m++; end
      g = exp_grant(req_valid, last_g);
      if (g < 0) g = 0;
      check_eq("grant", req_ready, NREQ'(1) << g);
      obs_g = 0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_g = i;
      obs_seq = {obs_seq[5:0], 2'(obs_g)};
      last_g  = g;
      ep = pt_a[g];
      ek = key_a[g];
      ec = stuck ? '0 : aes128(ep, ek);
      acc_cyc = cyc;
      we0 = we_count;
      rsp_ready = (bp == 0);
      step();
      if (keep) begin
         pt_a[g]  = rand128();
         key_a[g] = rand128();
      end else begin
         req_valid[g] = 1'b0;
      end
      drive_bus();
      if (stuck) force_busy = 1'b1;
      #1;
      check_eq("issue_we", core_we, 1);
      check_eq("issue_pt", core_plaintext, ep);
      check_eq("issue_key", core_secret, ek);
      quiet = (req_ready == '0);
      m = 0;
      step();
      while (!rsp_valid && m < 200) begin
         quiet &= (req_ready == '0) && !core_we;
         step();
         m++;
      end
      quiet &= (req_ready == '0);
      lat = cyc - acc_cyc;
      check_eq("latency", lat, stuck ? TO + 3 : 15);
      check_eq("cipher", rsp_cipher, ec);
      check_eq("id", rsp_id, g);
      check_eq("err", rsp_err, stuck);
      last_cipher = rsp_cipher;
      stable = 1'b1;
      for (int k = 0; k < bp; k++) begin
         step();
         stable &= rsp_valid && (rsp_cipher == ec) && (rsp_id == g) && (rsp_err == stuck);
         quiet  &= (req_ready == '0);
      end
      rsp_ready = 1'b1;
      step();
      check_eq("rsp_drop", rsp_valid, 0);
      check_eq("resp_hold", stable, 1);
      check_eq("no_grant_busy", quiet, 1);
      check_eq("we_once", we_count - we0, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #500000;
      $display("FAIL sim_limit: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
      reset_n    = 1'b0;
      req_valid  = '0;
      rsp_ready  = 1'b1;
      force_busy = 1'b0;
      obs_seq    = '0;
      last_g     = NREQ - 1;
      for (int i = 0; i < NREQ; i++) begin pt_a[i] = '0; key_a[i] = '0; end
      drive_bus();

      step();
      check_reset_vals();
      reset_n = 1'b1;
      step();

      // FIPS-197 appendix C.1
      pt_a[0]  = 128'h00112233445566778899aabbccddeeff;
      key_a[0] = 128'h000102030405060708090a0b0c0d0e0f;
      req_valid = 2'b01;
      drive_bus();
      do_op(0, 1'b0, 1'b0);
      check_eq("fips_cipher", last_cipher, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      // Both requesters continuously valid from a fresh pointer
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      last_g  = NREQ - 1;
      for (int i = 0; i < NREQ; i++) begin pt_a[i] = rand128(); key_a[i] = rand128(); end
      req_valid = '1;
      drive_bus();
      obs_seq = '0;
      for (int r = 0; r < 4; r++) begin
         prev_acc = acc_cyc;
         do_op(0, 1'b0, r < 3);
         if (r > 0) check_eq("thruput", acc_cyc - prev_acc, 16);
      end
`ifdef AES_SCHED_ROUND_ROBIN_EN
      check_eq("order", obs_seq, 8'b00_01_00_01);
`else
      check_eq("order", obs_seq, 8'b00_00_00_00);
`endif

      // Response backpressure
      if (!req_valid[0]) begin pt_a[0] = rand128(); key_a[0] = rand128(); req_valid[0] = 1'b1; end
      drive_bus();
      do_op(10, 1'b0, 1'b0);

      // Randomized traffic
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NREQ; i++)
            if (!req_valid[i] && $urandom_range(1) == 1) begin
               pt_a[i] = rand128(); key_a[i] = rand128(); req_valid[i] = 1'b1;
            end
         if (req_valid == '0) begin pt_a[0] = rand128(); key_a[0] = rand128(); req_valid[0] = 1'b1; end
         drive_bus();
         do_op(int'($urandom_range(3)), 1'b0, 1'b0);
      end
      n = 0;
      while (req_valid != '0 && n < NREQ) begin do_op(0, 1'b0, 1'b0); n++; end

      // Stuck core: watchdog abort, then no grant until busy falls
      pt_a[0] = rand128(); key_a[0] = rand128(); req_valid[0] = 1'b1;
      drive_bus();
      do_op(0, 1'b1, 1'b0);
      pt_a[1] = rand128(); key_a[1] = rand128(); req_valid[1] = 1'b1;
      drive_bus();
      #1;
      q = 1'b1;
      for (int k = 0; k < 5; k++) begin q &= (req_ready == '0); step(); end
      check_eq("stuck_no_grant", q, 1);
      force_busy = 1'b0;
      #1;
      check_eq("stuck_regrant", req_ready, 2'b10);
      do_op(0, 1'b0, 1'b0);

      // Reset in the middle of WAIT with the core still busy
      pt_a[0] = rand128(); key_a[0] = rand128(); req_valid[0] = 1'b1;
      drive_bus();
      #1;
      check_eq("rst_pre_grant", req_ready, 2'b01);
      t0 = cyc;
      step();
      req_valid[0] = 1'b0;
      repeat (5) step();
      reset_n = 1'b0;
      pt_a[1] = rand128(); key_a[1] = rand128(); req_valid[1] = 1'b1;
      drive_bus();
      #1;
      check_reset_vals();
      step();
      step();
      reset_n = 1'b1;
      last_g  = NREQ - 1;
      #1;
      n = 0;
      while (req_ready == '0 && n < 50) begin step(); n++; end
      check_eq("rst_regrant_cyc", cyc - t0, 14);
      check_eq("rst_regrant", req_ready, 2'b10);
      do_op(0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
